reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Consumes the recovered system reset and releases NUM_STAGES downstream
//  reset domains one at a time, in order: PLL/clocking, memory, core, I/O.
//  Each stage is released only after the previous stage acknowledges ready
//  and a fixed settle gap has elapsed. Missing acknowledges are caught by
//  timeout and the block falls back to full reset.
//  Sits directly after the reset-recovery stage. Its active-low reset output
//  is inverted at instantiation to drive rst here.
// PARAMETERS
//  NUM_STAGES   4      number of sequenced reset domains (1..8)
//  STAGE_DLY    1000   clk cycles of settle gap before each release
//  ACK_TIMEOUT  50000  clk cycles to wait for stage_ack before fault
//  CNT_W        16     counter width; must hold max(STAGE_DLY, ACK_TIMEOUT)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           async, active-high; asserts all rst_out immediately
//  stage_ack    in   NUM_STAGES  per-stage ready level; asynchronous to clk
//  soft_req     in   1           1-cycle pulse: re-run the sequence from DONE or FAULT
//  rst_out      out  NUM_STAGES  per-domain reset, active-high (1 = held in reset)
//  seq_done     out  1           1 = all stages released and acknowledged
//  timeout_err  out  1           sticky; set on ack timeout
//  cur_stage    out  3           index of the stage being processed (debug)
// BEHAVIOUR
//  Reset values
//   - rst_out = all 1s; seq_done = 0; timeout_err = 0; cur_stage = 0.
//   - State = HOLD; counter = 0.
//   - Assertion of rst takes effect asynchronously, mid-sequence included.
//  Input handling
//   - stage_ack passes through a 2-flop synchronizer (2 cycles latency).
//   - The FSM uses the synchronized value only.
//  States
//   - HOLD: count STAGE_DLY cycles, then go to RELEASE.
//   - RELEASE: clear rst_out[cur_stage] (single cycle); counter <= 0; go to WAIT_ACK.
//   - WAIT_ACK:
//       synced ack[cur_stage] = 1:
//         if cur_stage = NUM_STAGES-1, go to DONE;
//         otherwise cur_stage++, counter <= 0, go to HOLD.
//       counter reaches ACK_TIMEOUT-1 with no ack: go to FAULT.
//   - DONE: seq_done = 1 (registered). Stay until soft_req.
//   - FAULT: on entry, set rst_out = all 1s and timeout_err = 1.
//       Stay until soft_req.
//  Release timing
//   - rst_out[k] falls exactly STAGE_DLY+1 cycles after the previous stage's
//     synced ack is seen; for stage 0, after rst deasserts.
//   - Stages are released strictly in ascending index, never two in one cycle.
//  Acknowledges
//   - Ack is level-sampled. An ack already high at RELEASE is accepted in the
//     first WAIT_ACK cycle.
//   - Ack dropping after DONE is ignored; no re-sequencing.
//  soft_req
//   - Accepted only in DONE or FAULT; ignored elsewhere.
//   - On acceptance: rst_out = all 1s, seq_done = 0, timeout_err = 0,
//     cur_stage = 0, counter = 0, go to HOLD.
//  Simultaneous events
//   - soft_req and timeout in the same cycle: timeout wins.
//   - rst overrides everything.
//  Counter rules
//   - Counter saturates; it never wraps.
//   - STAGE_DLY = 0 gives HOLD a 1-cycle dwell.
// STRUCTURE
//  rst_seq_pkg
//   - State encoding localparams: HOLD, RELEASE, WAIT_ACK, DONE, FAULT (3-bit).
//   - Default delay constants.
//  Sub-module ack_sync
//   - Parameterised-width 2-flop synchronizer, async-reset to 0.
//   - One instance, covering all of stage_ack.
//  Top level
//   - Single FSM plus one shared CNT_W counter.
//   - All outputs are registered.
// TESTING  (bench params: NUM_STAGES=3, STAGE_DLY=4, ACK_TIMEOUT=10)
//  1. Reset, then acks raised 3 cycles after each release
//     -> rst_out steps 111 -> 110 -> 100 -> 000 in order; seq_done = 1;
//        each release gap = 5 cycles + sync latency + ack delay.
//  2. ack[1] never asserted
//     -> FAULT 10 cycles after stage-1 release; rst_out = 111;
//        timeout_err = 1; seq_done = 0.
//  3. soft_req pulse in FAULT with all acks tied high
//     -> timeout_err clears; full sequence reruns; seq_done = 1.
//  4. rst asserted during WAIT_ACK of stage 2
//     -> rst_out = 111 with no clock edge;
//        after release, sequence restarts at stage 0.
//  5. soft_req in HOLD or WAIT_ACK -> ignored; sequence timing unchanged.
//  6. Acks pre-asserted before reset release
//     -> each stage accepted on its first WAIT_ACK cycle;
//        no stage released early.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared state encoding and default timing constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_RELEASE  = 3'd1,
    ST_WAIT_ACK = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } seq_state_e;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_STAGE_DLY   = 1000;
  localparam int DEF_ACK_TIMEOUT = 50000;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchronizer for a bus of independent level signals, async-reset to 0.
module ack_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in ascending order, each after a settle gap
// and the previous domain's acknowledge; a missing acknowledge forces full reset.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int STAGE_DLY   = DEF_STAGE_DLY,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stage_ack,
  input  logic                  soft_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  seq_done,
  output logic                  timeout_err,
  output logic [2:0]            cur_stage
);

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  seq_done_q, seq_done_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [2:0]            cur_stage_q, cur_stage_d;

  logic [NUM_STAGES-1:0] ack_s;
  logic [NUM_STAGES-1:0] stage_mask;
  logic                  cur_ack;
  logic                  last_stage;
  logic                  hold_done;
  logic                  ack_expired;

  ack_sync #(
    .WIDTH(NUM_STAGES)
  ) u_ack_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (stage_ack),
    .sync_out (ack_s)
  );

  always_comb begin
    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    stage_mask  = NUM_STAGES'(1) << cur_stage_q;
    cur_ack     = |(ack_s & stage_mask);
    last_stage  = (cur_stage_q == 3'(NUM_STAGES - 1));
    hold_done   = (cnt_q >= CNT_W'(STAGE_DLY));
    // Fault is taken on the edge where the count would reach ACK_TIMEOUT-1,
    // which lands ACK_TIMEOUT cycles after the stage's rst_out falls.
    ack_expired = (cnt_inc >= CNT_W'(ACK_TIMEOUT - 1));
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rst_out_d     = rst_out_q;
    seq_done_d    = seq_done_q;
    timeout_err_d = timeout_err_q;
    cur_stage_d   = cur_stage_q;

    unique case (state_q)
      ST_HOLD: begin
        if (hold_done) begin
          // Clear on the way in so the registered output drops with RELEASE.
          rst_out_d = rst_out_q & ~stage_mask;
          state_d   = ST_RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RELEASE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        if (cur_ack) begin
          if (last_stage) begin
            seq_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cur_stage_d = cur_stage_q + 3'd1;
            cnt_d       = '0;
            state_d     = ST_HOLD;
          end
        end else if (ack_expired) begin
          rst_out_d     = '1;
          timeout_err_d = 1'b1;
          state_d       = ST_FAULT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_DONE, ST_FAULT: begin
        if (soft_req) begin
          rst_out_d     = '1;
          seq_done_d    = 1'b0;
          timeout_err_d = 1'b0;
          cur_stage_d   = '0;
          cnt_d         = '0;
          state_d       = ST_HOLD;
        end
      end

      default: begin
        rst_out_d     = '1;
        seq_done_d    = 1'b0;
        cur_stage_d   = '0;
        cnt_d         = '0;
        state_d       = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      rst_out_q     <= '1;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cur_stage_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rst_out_q     <= rst_out_d;
      seq_done_q    <= seq_done_d;
      timeout_err_q <= timeout_err_d;
      cur_stage_q   <= cur_stage_d;
    end
  end

  assign rst_out     = rst_out_q;
  assign seq_done    = seq_done_q;
  assign timeout_err = timeout_err_q;
  assign cur_stage   = cur_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_STAGES=3, STAGE_DLY=4, ACK_TIMEOUT=10.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic [2:0] stage_ack;
  logic       soft_req;
  logic [2:0] rst_out;
  logic       seq_done;
  logic       timeout_err;
  logic [2:0] cur_stage;

  int total;
  int bad;

  reset_sequencer #(
    .NUM_STAGES  (3),
    .STAGE_DLY   (4),
    .ACK_TIMEOUT (10),
    .CNT_W       (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stage_ack   (stage_ack),
    .soft_req    (soft_req),
    .rst_out     (rst_out),
    .seq_done    (seq_done),
    .timeout_err (timeout_err),
    .cur_stage   (cur_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Timing notes (edges counted from the HOLD entry point E0):
  //   stage release at E5; an ack driven 2 negedges after a release (first
  //   sync flop captures it on the 3rd edge) is acted on 5 edges after the
  //   release, so the next release is 10 edges after the previous one.
  //   Pre-asserted acks: next release 7 edges later. Timeout: 10 edges.
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    stage_ack = 3'b000;
    soft_req  = 1'b0;
    step(2);
    chk("rst_rst_out",     32'(rst_out),     32'd7);
    chk("rst_seq_done",    32'(seq_done),    32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_cur_stage",   32'(cur_stage),   32'd0);

    // 1. normal sequence, acks 3 cycles after each release
    rst = 1'b0;
    step(4); chk("t1_hold0",  32'(rst_out), 32'd7);
    step(1); chk("t1_rel0",   32'(rst_out), 32'd6);
             chk("t1_cur0",   32'(cur_stage), 32'd0);
    step(2); stage_ack = 3'b001;
    step(7); chk("t1_gap1",   32'(rst_out), 32'd6);
             chk("t1_cur1",   32'(cur_stage), 32'd1);
    step(1); chk("t1_rel1",   32'(rst_out), 32'd4);
    step(2); stage_ack = 3'b011;
    step(7); chk("t1_gap2",   32'(rst_out), 32'd4);
    step(1); chk("t1_rel2",   32'(rst_out), 32'd0);
             chk("t1_cur2",   32'(cur_stage), 32'd2);
    step(2); stage_ack = 3'b111;
    step(2); chk("t1_notdone", 32'(seq_done), 32'd0);
    step(1); chk("t1_done",    32'(seq_done), 32'd1);
             chk("t1_done_ro", 32'(rst_out),  32'd0);
    stage_ack = 3'b000;
    step(5); chk("t1_ackdrop_done", 32'(seq_done), 32'd1);
             chk("t1_ackdrop_ro",   32'(rst_out),  32'd0);

    // soft_req from DONE restarts the sequence
    soft_req = 1'b1;
    step(1); soft_req = 1'b0;
    chk("sr_done_ro",   32'(rst_out),   32'd7);
    chk("sr_done_done", 32'(seq_done),  32'd0);
    chk("sr_done_cur",  32'(cur_stage), 32'd0);

    // 2. ack[1] never arrives
    step(4); chk("t2_hold0", 32'(rst_out), 32'd7);
    step(1); chk("t2_rel0",  32'(rst_out), 32'd6);
    step(2); stage_ack = 3'b001;
    step(8); chk("t2_rel1",  32'(rst_out), 32'd4);
    step(9); chk("t2_pre_ro",   32'(rst_out),     32'd4);
             chk("t2_pre_terr", 32'(timeout_err), 32'd0);
    step(1); chk("t2_fault_ro",   32'(rst_out),     32'd7);
             chk("t2_fault_terr", 32'(timeout_err), 32'd1);
             chk("t2_fault_done", 32'(seq_done),    32'd0);
    step(5); chk("t2_stay_ro",   32'(rst_out),     32'd7);
             chk("t2_stay_terr", 32'(timeout_err), 32'd1);

    // 3. soft_req in FAULT, acks tied high
    stage_ack = 3'b111;
    soft_req  = 1'b1;
    step(1); soft_req = 1'b0;
    chk("t3_terr_clr", 32'(timeout_err), 32'd0);
    chk("t3_ro",       32'(rst_out),     32'd7);
    chk("t3_cur",      32'(cur_stage),   32'd0);
    step(4); chk("t3_hold0", 32'(rst_out), 32'd7);
    step(1); chk("t3_rel0",  32'(rst_out), 32'd6);
    step(6); chk("t3_gap1",  32'(rst_out), 32'd6);
    step(1); chk("t3_rel1",  32'(rst_out), 32'd4);
    step(6); chk("t3_gap2",  32'(rst_out), 32'd4);
    step(1); chk("t3_rel2",  32'(rst_out), 32'd0);
    step(1); chk("t3_notdone", 32'(seq_done), 32'd0);
    step(1); chk("t3_done",    32'(seq_done), 32'd1);
             chk("t3_terr",    32'(timeout_err), 32'd0);

    // async reset from DONE, then 5. soft_req ignored in HOLD / WAIT_ACK
    rst = 1'b1;
    #1;
    chk("t5_async_ro",   32'(rst_out),  32'd7);
    chk("t5_async_done", 32'(seq_done), 32'd0);
    step(1);
    stage_ack = 3'b000;
    rst       = 1'b0;
    step(2); soft_req = 1'b1;
    step(1); soft_req = 1'b0;
    step(1); chk("t5_hold0", 32'(rst_out), 32'd7);
    step(1); chk("t5_rel0",  32'(rst_out), 32'd6);
             chk("t5_cur0",  32'(cur_stage), 32'd0);
    step(2); stage_ack = 3'b001; soft_req = 1'b1;
    step(1); soft_req = 1'b0;
    step(6); chk("t5_gap1", 32'(rst_out),     32'd6);
             chk("t5_terr", 32'(timeout_err), 32'd0);
    step(1); chk("t5_rel1", 32'(rst_out),     32'd4);
             chk("t5_cur1", 32'(cur_stage),   32'd1);

    // 4. rst during WAIT_ACK of stage 2
    step(2); stage_ack = 3'b011;
    step(8); chk("t4_rel2", 32'(rst_out),   32'd0);
             chk("t4_cur2", 32'(cur_stage), 32'd2);
    step(2);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_ro",   32'(rst_out),   32'd7);
    chk("t4_async_cur",  32'(cur_stage), 32'd0);
    chk("t4_async_done", 32'(seq_done),  32'd0);

    // 6. acks pre-asserted before reset release
    stage_ack = 3'b111;
    step(2);
    rst = 1'b0;
    step(4); chk("t6_hold0", 32'(rst_out),   32'd7);
             chk("t6_cur0",  32'(cur_stage), 32'd0);
    step(1); chk("t6_rel0",  32'(rst_out), 32'd6);
    step(6); chk("t6_gap1",  32'(rst_out), 32'd6);
    step(1); chk("t6_rel1",  32'(rst_out), 32'd4);
    step(6); chk("t6_gap2",  32'(rst_out), 32'd4);
    step(1); chk("t6_rel2",  32'(rst_out), 32'd0);
    step(1); chk("t6_notdone", 32'(seq_done), 32'd0);
    step(1); chk("t6_done",    32'(seq_done), 32'd1);
             chk("t6_terr",    32'(timeout_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
